// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one 4-bit ALU, result returned with valid/ready and requester ID
// Optional build macro ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie instead of round-robin.
module alu_arbiter #(
  parameter int NREQ = 2,
  parameter int W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  input  logic [2*NREQ-1:0] req_op,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_id,
  output logic [2*W-1:0]    resp_r,
  output logic [3:0]        resp_flags,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic         last_grant;
  logic         win_id;
  logic         win_any;
  logic         grant;

  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [1:0]   op_code;
  logic         op_id;

  logic [2*W-1:0] alu_r;
  logic [W:0]     diff;
  logic           alu_z;
  logic           alu_n;
  logic           alu_c;
  logic           alu_v;

  // Tie-break: the requester that was not served last, unless fixed priority is built in.
  always_comb begin
    win_id = 1'b0;
    case (req_valid)
      2'b10: win_id = 1'b1;
      2'b11: begin
`ifdef ALU_ARB_FIXED_PRIO_EN
        win_id = 1'b0;
`else
        win_id = ~last_grant;
`endif
      end
      default: win_id = 1'b0;
    endcase
  end

  assign win_any = |req_valid;

  always_comb begin
    req_ready = '0;
    if (state == IDLE && win_any) begin
      req_ready[win_id] = 1'b1;
    end
  end

  assign grant      = |(req_valid & req_ready);
  assign resp_valid = (state == RESP);
  assign busy       = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (grant) begin
          state_nxt = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        if (resp_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operands are sampled only on the handshake edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      op_code <= '0;
      op_id   <= 1'b0;
    end else if (grant) begin
      op_a    <= win_id ? req_a[2*W-1:W] : req_a[W-1:0];
      op_b    <= win_id ? req_b[2*W-1:W] : req_b[W-1:0];
      op_code <= win_id ? req_op[3:2]    : req_op[1:0];
      op_id   <= win_id;
    end
  end

  // Shared ALU, driven only from the operand registers.
  always_comb begin
    alu_r = '0;
    diff  = '0;
    alu_c = 1'b0;
    alu_v = 1'b0;
    case (op_code)
      2'b00: alu_r = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
      2'b01: begin
        diff  = {1'b0, op_a} - {1'b0, op_b};
        alu_r = {{W{1'b0}}, diff[W-1:0]};
        alu_c = diff[W];
        alu_v = (op_a[W-1] != op_b[W-1]) && (diff[W-1] != op_a[W-1]);
      end
      2'b10: alu_r = {{W{1'b0}}, op_a & op_b};
      default: alu_r = {{W{1'b0}}, op_a ^ op_b};
    endcase
    alu_z = (op_code == 2'b00) ? (alu_r == '0) : (alu_r[W-1:0] == '0);
    alu_n = (op_code == 2'b00) ? alu_r[2*W-1] : alu_r[W-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      resp_r     <= '0;
      resp_flags <= '0;
      resp_id    <= 1'b0;
      last_grant <= 1'b1;
    end else if (state == EXEC) begin
      resp_r     <= alu_r;
      resp_flags <= {alu_z, alu_n, alu_c, alu_v};
      resp_id    <= op_id;
      last_grant <= op_id;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed and randomized checks of alu_arbiter against a behavioural model
module tb_alu_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req_valid;
  logic [1:0] req_ready;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic [3:0] req_op;
  logic       resp_valid;
  logic       resp_ready;
  logic       resp_id;
  logic [7:0] resp_r;
  logic [3:0] resp_flags;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  logic last   = 1'b1;

  logic       gid;
  logic [7:0] gr;
  logic [3:0] gf;
  logic [3:0] exp_ids;

  alu_arbiter #(.NREQ(2), .W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_r     (resp_r),
    .resp_flags (resp_flags),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_winner(input logic [1:0] v, input logic lg);
    if (v == 2'b01) return 1'b0;
    if (v == 2'b10) return 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return !lg;
`endif
  endfunction

  // Returns {result[7:0], Z, N, C, V} using plain integer arithmetic.
  function automatic logic [11:0] alu_model(input int a, input int b, input int op);
    int   r;
    int   sa;
    int   sb;
    int   sd;
    logic z;
    logic n;
    logic c;
    logic v;
    c = 1'b0;
    v = 1'b0;
    case (op)
      0: r = a * b;
      1: begin
        r  = (a - b) & 15;
        c  = (a < b);
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        sd = sa - sb;
        v  = (sd < -8) || (sd > 7);
      end
      2: r = a & b;
      default: r = a ^ b;
    endcase
    z = (r == 0);
    n = (op == 0) ? (r >= 128) : (r >= 8);
    return {r[7:0], z, n, c, v};
  endfunction

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_resp_valid"}, 32'(resp_valid), 0);
    check({pfx, "_resp_id"},    32'(resp_id), 0);
    check({pfx, "_resp_r"},     32'(resp_r), 0);
    check({pfx, "_resp_flags"}, 32'(resp_flags), 0);
    check({pfx, "_req_ready"},  32'(req_ready), 0);
    check({pfx, "_busy"},       32'(busy), 0);
  endtask

  task automatic run_op(input logic [1:0] v, input logic [7:0] a, input logic [7:0] b,
                        input logic [3:0] op, input int stall,
                        output logic oid, output logic [7:0] orr, output logic [3:0] ofl);
    logic        w;
    logic [11:0] e;
    @(negedge clk);
    req_valid  = v;
    req_a      = a;
    req_b      = b;
    req_op     = op;
    resp_ready = 1'b0;
    w = exp_winner(v, last);
    if (w) e = alu_model(int'(a[7:4]), int'(b[7:4]), int'(op[3:2]));
    else   e = alu_model(int'(a[3:0]), int'(b[3:0]), int'(op[1:0]));
    #1;
    check("idle_req_ready", 32'(req_ready), w ? 2 : 1);
    check("idle_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    req_valid = 2'($urandom);
    req_a     = 8'($urandom);
    req_b     = 8'($urandom);
    req_op    = 4'($urandom);
    last      = w;
    @(negedge clk);
    check("exec_resp_valid", 32'(resp_valid), 0);
    check("exec_busy", 32'(busy), 1);
    check("exec_req_ready", 32'(req_ready), 0);
    @(negedge clk);
    check("resp_valid", 32'(resp_valid), 1);
    check("resp_id", 32'(resp_id), 32'(w));
    check("resp_r", 32'(resp_r), 32'(e[11:4]));
    check("resp_flags", 32'(resp_flags), 32'(e[3:0]));
    oid = resp_id;
    orr = resp_r;
    ofl = resp_flags;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      req_valid = 2'($urandom);
      req_a     = 8'($urandom);
      #1;
      check("stall_resp_valid", 32'(resp_valid), 1);
      check("stall_resp_r", 32'(resp_r), 32'(e[11:4]));
      check("stall_resp_flags", 32'(resp_flags), 32'(e[3:0]));
      check("stall_resp_id", 32'(resp_id), 32'(w));
      check("stall_req_ready", 32'(req_ready), 0);
      check("stall_busy", 32'(busy), 1);
    end
    req_valid  = 2'b00;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("post_resp_valid", 32'(resp_valid), 0);
    check("post_busy", 32'(busy), 0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    req_a      = 8'h00;
    req_b      = 8'h00;
    req_op     = 4'h0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    run_op(2'b01, 8'h03, 8'h05, 4'b0000, 0, gid, gr, gf);
    check("tp_mul35_id", 32'(gid), 0);
    check("tp_mul35_r", 32'(gr), 32'h0F);
    check("tp_mul35_f", 32'(gf), 32'h0);

    run_op(2'b10, 8'hF0, 8'hF0, 4'b0000, 0, gid, gr, gf);
    check("tp_mulff_id", 32'(gid), 1);
    check("tp_mulff_r", 32'(gr), 32'hE1);
    check("tp_mulff_f", 32'(gf), 32'b0100);

    run_op(2'b10, 8'hF0, 8'hF0, 4'b1100, 0, gid, gr, gf);
    check("tp_xorff_r", 32'(gr), 32'h00);
    check("tp_xorff_f", 32'(gf), 32'b1000);

    run_op(2'b01, 8'h0C, 8'h0A, 4'b0010, 0, gid, gr, gf);
    check("tp_and_r", 32'(gr), 32'h08);
    check("tp_and_f", 32'(gf), 32'b0100);

    // Both requesters valid from a fresh reset.
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst  = 1'b0;
    last = 1'b1;
`ifdef ALU_ARB_FIXED_PRIO_EN
    exp_ids = 4'b0000;
`else
    exp_ids = 4'b1010;
`endif
    for (int k = 0; k < 4; k++) begin
      run_op(2'b11, 8'h21, 8'h43, 4'b0110, 0, gid, gr, gf);
      check("tie_id", 32'(gid), 32'(exp_ids[k]));
    end

    run_op(2'b01, 8'h07, 8'h09, 4'b0001, 4, gid, gr, gf);

    // Reset while in EXEC.
    @(negedge clk);
    req_valid = 2'b01;
    req_a     = 8'h03;
    req_b     = 8'h05;
    req_op    = 4'b0000;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_exec");
    @(negedge clk);
    rst  = 1'b0;
    last = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("rst_exec_no_resp", 32'(resp_valid), 0);
    end
    run_op(2'b11, 8'h56, 8'h12, 4'b0101, 1, gid, gr, gf);

    // Reset while in RESP.
    @(negedge clk);
    req_valid = 2'b10;
    req_a     = 8'h90;
    req_b     = 8'h30;
    req_op    = 4'b0100;
    @(posedge clk);
    #1;
    req_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("rst_resp_pre_valid", 32'(resp_valid), 1);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_resp");
    @(negedge clk);
    rst  = 1'b0;
    last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_resp_no_resp", 32'(resp_valid), 0);
    end

    for (int k = 0; k < 40; k++) begin
      run_op(2'($urandom_range(1, 3)), 8'($urandom), 8'($urandom), 4'($urandom),
             $urandom_range(0, 3), gid, gr, gf);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
